// File: rtl/reservation_station_if.sv
// Dispatch, common-data-bus and functional-unit signals of a reservation-station bank.
// The slave modport is the station; the master modport is the environment around it.
interface reservation_station_if #(
    parameter int ENTRIES = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 7
);
    localparam int SEL_W = $clog2(ENTRIES);

    // dispatch request and feedback
    logic               disp_valid;
    logic [SEL_W-1:0]   disp_sel;
    logic [OP_W-1:0]    disp_op;
    logic [TAG_W-1:0]   disp_dest;
    logic [TAG_W-1:0]   disp_qj;
    logic [TAG_W-1:0]   disp_qk;
    logic [XLEN-1:0]    disp_vj;
    logic [XLEN-1:0]    disp_vk;
    logic [ENTRIES-1:0] busy;
    logic               disp_err;

    // result broadcast
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [XLEN-1:0]    cdb_data;

    // functional-unit issue port
    logic               fu_valid;
    logic               fu_ready;
    logic [OP_W-1:0]    fu_op;
    logic [XLEN-1:0]    fu_a;
    logic [XLEN-1:0]    fu_b;
    logic [TAG_W-1:0]   fu_tag;

    modport slave (
        input  disp_valid, disp_sel, disp_op, disp_dest, disp_qj, disp_qk, disp_vj, disp_vk,
        output busy, disp_err,
        input  cdb_valid, cdb_tag, cdb_data,
        output fu_valid, fu_op, fu_a, fu_b, fu_tag,
        input  fu_ready
    );

    modport master (
        output disp_valid, disp_sel, disp_op, disp_dest, disp_qj, disp_qk, disp_vj, disp_vk,
        input  busy, disp_err,
        output cdb_valid, cdb_tag, cdb_data,
        input  fu_valid, fu_op, fu_a, fu_b, fu_tag,
        output fu_ready
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation-station bank: per-entry operand capture from the CDB, round-robin
// selection of ready entries and a registered valid/ready issue stage.
module reservation_station #(
    parameter int ENTRIES = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    reservation_station_if.slave rs_if
);
    localparam int SEL_W = $clog2(ENTRIES);

    // per-entry views gathered for selection and the issue mux
    logic [ENTRIES-1:0] occ_w;
    logic [ENTRIES-1:0] ready_w;
    logic [ENTRIES-1:0] grant_w;
    logic [OP_W-1:0]    op_w   [ENTRIES];
    logic [TAG_W-1:0]   dest_w [ENTRIES];
    logic [XLEN-1:0]    vj_w   [ENTRIES];
    logic [XLEN-1:0]    vk_w   [ENTRIES];

    logic [SEL_W-1:0]   rr_q, rr_d;
    logic [SEL_W-1:0]   gidx_w;
    logic               found_w;
    logic               stage_open_w;
    logic               grant_any_w;
    logic               cdb_live_w;

    logic               fu_valid_q, fu_valid_d;
    logic [OP_W-1:0]    fu_op_q, fu_op_d;
    logic [XLEN-1:0]    fu_a_q, fu_a_d;
    logic [XLEN-1:0]    fu_b_q, fu_b_d;
    logic [TAG_W-1:0]   fu_tag_q, fu_tag_d;
    logic               disp_err_q, disp_err_d;

    // tag 0 is the "no producer" marker, so a broadcast of tag 0 is inert
    assign cdb_live_w   = rs_if.cdb_valid && (rs_if.cdb_tag != '0);
    assign stage_open_w = !fu_valid_q || rs_if.fu_ready;

    // Round-robin search from rr over registered ready bits only, so an entry
    // woken at an edge is never issued at that same edge.
    always_comb begin
        found_w = 1'b0;
        gidx_w  = rr_q;
        for (int k = 0; k < ENTRIES; k++) begin
            if (!found_w && ready_w[rr_q + SEL_W'(k)]) begin
                found_w = 1'b1;
                gidx_w  = rr_q + SEL_W'(k);
            end
        end
    end

    assign grant_any_w = stage_open_w && found_w && !flush_i;

    // One-hot grant so the selected entry can free itself
    always_comb begin
        grant_w = '0;
        if (grant_any_w) begin
            grant_w[gidx_w] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic             occ_q, occ_d;
        logic [OP_W-1:0]  op_q, op_d;
        logic [TAG_W-1:0] dest_q, dest_d;
        logic [TAG_W-1:0] qj_q, qj_d;
        logic [TAG_W-1:0] qk_q, qk_d;
        logic [XLEN-1:0]  vj_q, vj_d;
        logic [XLEN-1:0]  vk_q, vk_d;
        logic             disp_hit;
        logic             byp_j, byp_k;
        logic             cap_j, cap_k;

        // Entry next state: flush beats dispatch, dispatch only lands in a free
        // entry (so it never meets a grant or capture), otherwise grant/capture.
        always_comb begin
            disp_hit = rs_if.disp_valid && (rs_if.disp_sel == SEL_W'(gi)) && !occ_q;
            byp_j    = cdb_live_w && (rs_if.disp_qj == rs_if.cdb_tag);
            byp_k    = cdb_live_w && (rs_if.disp_qk == rs_if.cdb_tag);
            cap_j    = cdb_live_w && occ_q && (qj_q == rs_if.cdb_tag);
            cap_k    = cdb_live_w && occ_q && (qk_q == rs_if.cdb_tag);
            occ_d    = occ_q;
            op_d     = op_q;
            dest_d   = dest_q;
            qj_d     = qj_q;
            qk_d     = qk_q;
            vj_d     = vj_q;
            vk_d     = vk_q;
            if (flush_i) begin
                occ_d = 1'b0;
            end else if (disp_hit) begin
                occ_d  = 1'b1;
                op_d   = rs_if.disp_op;
                dest_d = rs_if.disp_dest;
                qj_d   = byp_j ? '0 : rs_if.disp_qj;
                vj_d   = byp_j ? rs_if.cdb_data : rs_if.disp_vj;
                qk_d   = byp_k ? '0 : rs_if.disp_qk;
                vk_d   = byp_k ? rs_if.cdb_data : rs_if.disp_vk;
            end else begin
                if (grant_w[gi]) begin
                    occ_d = 1'b0;
                end
                if (cap_j) begin
                    qj_d = '0;
                    vj_d = rs_if.cdb_data;
                end
                if (cap_k) begin
                    qk_d = '0;
                    vk_d = rs_if.cdb_data;
                end
            end
        end

        // Entry state registers
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                occ_q  <= 1'b0;
                op_q   <= '0;
                dest_q <= '0;
                qj_q   <= '0;
                qk_q   <= '0;
                vj_q   <= '0;
                vk_q   <= '0;
            end else begin
                occ_q  <= occ_d;
                op_q   <= op_d;
                dest_q <= dest_d;
                qj_q   <= qj_d;
                qk_q   <= qk_d;
                vj_q   <= vj_d;
                vk_q   <= vk_d;
            end
        end

        assign occ_w[gi]   = occ_q;
        assign ready_w[gi] = occ_q && (qj_q == '0) && (qk_q == '0);
        assign op_w[gi]    = op_q;
        assign dest_w[gi]  = dest_q;
        assign vj_w[gi]    = vj_q;
        assign vk_w[gi]    = vk_q;
    end

    // Issue stage, pointer and sticky error next state
    always_comb begin
        fu_valid_d = fu_valid_q;
        fu_op_d    = fu_op_q;
        fu_a_d     = fu_a_q;
        fu_b_d     = fu_b_q;
        fu_tag_d   = fu_tag_q;
        rr_d       = rr_q;
        disp_err_d = disp_err_q | (rs_if.disp_valid && occ_w[rs_if.disp_sel]);
        if (flush_i) begin
            fu_valid_d = 1'b0;
            rr_d       = '0;
        end else if (grant_any_w) begin
            fu_valid_d = 1'b1;
            fu_op_d    = op_w[gidx_w];
            fu_a_d     = vj_w[gidx_w];
            fu_b_d     = vk_w[gidx_w];
            fu_tag_d   = dest_w[gidx_w];
            rr_d       = gidx_w + 1'b1;
        end else if (fu_valid_q && rs_if.fu_ready) begin
            fu_valid_d = 1'b0;
        end
    end

    // Issue stage, pointer and error registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fu_valid_q <= 1'b0;
            fu_op_q    <= '0;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            fu_tag_q   <= '0;
            rr_q       <= '0;
            disp_err_q <= 1'b0;
        end else begin
            fu_valid_q <= fu_valid_d;
            fu_op_q    <= fu_op_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            fu_tag_q   <= fu_tag_d;
            rr_q       <= rr_d;
            disp_err_q <= disp_err_d;
        end
    end

    assign rs_if.busy     = occ_w;
    assign rs_if.disp_err = disp_err_q;
    assign rs_if.fu_valid = fu_valid_q;
    assign rs_if.fu_op    = fu_op_q;
    assign rs_if.fu_a     = fu_a_q;
    assign rs_if.fu_b     = fu_b_q;
    assign rs_if.fu_tag   = fu_tag_q;
endmodule

// File: doc/reservation_station.md
# reservation_station

Bank of reservation-station entries directly downstream of the issue queue's dispatch stage. It accepts one dispatched task per cycle into an entry selected by the dispatcher, and captures missing source operands from the common data bus (CDB). It presents one ready task at a time to its functional unit through a registered valid/ready output stage. Per-entry busy bits feed back to the dispatcher as its `rs_busy` input slice.

## Interface
- `ENTRIES`, 2: number of entries in the bank (power of two, 2..8).
- `XLEN`, 32: operand and result width.
- `TAG_W`, 4: producer tag width; tag 0 means "value present, no producer".
- `OP_W`, 7: opcode/function field width, passed through unchanged.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `FLUSH`  in  1  synchronous clear of all entries and the output stage.
- `DISP_VALID`  in  1  dispatch request this cycle.
- `DISP_SEL`  in  $clog2(ENTRIES)  target entry index.
- `DISP_OP`  in  OP_W  operation.
- `DISP_DEST`  in  TAG_W  result tag of the dispatched task.
- `DISP_QJ`, `DISP_QK`  in  TAG_W  source producer tags.
- `DISP_VJ`, `DISP_VK`  in  XLEN  source values (meaningful when the matching Q is 0).
- `CDB_VALID`  in  1  broadcast valid.
- `CDB_TAG`  in  TAG_W  broadcast tag.
- `CDB_DATA`  in  XLEN  broadcast value.
- `BUSY`  out  ENTRIES  bit i high while entry i is not FREE.
- `DISP_ERR`  out  1  sticky; set by a dispatch to a busy entry.
- `FU_VALID`  out  1  output stage holds a task.
- `FU_READY`  in  1  functional unit accepts.
- `FU_OP`  out  OP_W  operation.
- `FU_A`, `FU_B`  out  XLEN  operands.
- `FU_TAG`  out  TAG_W  destination tag.

## Operation
- Each entry holds the fields op, dest, qj, vj, qk, vk and a 2-state flag: FREE or OCCUPIED. The entry is READY when it is OCCUPIED and qj==0 and qk==0.
- Dispatch: when `DISP_VALID` is high and entry `DISP_SEL` is FREE, load all fields and set OCCUPIED.
  - If `DISP_SEL` is OCCUPIED, the request is ignored, the entry is unchanged and `DISP_ERR` is set. `DISP_ERR` clears only on reset.
- CDB capture: when `CDB_VALID` is high and `CDB_TAG`≠0, every OCCUPIED entry with qj==`CDB_TAG` loads vj←`CDB_DATA` and qj←0. The same applies to qk/vk independently. Both operands may capture in the same cycle.
- Dispatch/CDB bypass: if a dispatched Q equals a valid nonzero `CDB_TAG` in the same cycle, that operand is stored as captured (Q=0, V=`CDB_DATA`).
- `CDB_TAG`=0 never matches anything.
- Output stage: a register set holding op, A, B, tag and a valid bit. It is "open" when it is empty, or when `FU_VALID` && `FU_READY` this cycle.
- Selection: when the stage is open and at least one entry is READY, one entry is granted. Grant is round-robin starting at pointer `rr`.
  - The granted entry's op, vj, vk and dest load into the output stage, and the entry becomes FREE at the same edge.
  - `rr` ← granted index + 1 (mod ENTRIES).
- An entry that becomes READY through CDB capture or dispatch at edge N can be granted no earlier than edge N+1. Selection uses registered entry state only.
- The output stage holds its contents stable while `FU_VALID` && !`FU_READY`.
- `FLUSH` sets all entries FREE, clears the output valid bit and resets `rr` to 0. `FLUSH` dominates any dispatch, capture or grant in the same cycle. `DISP_ERR` is unaffected by `FLUSH`.

## Timing
- Reset (`RST_N` low, asynchronous): all entries FREE, `BUSY`=0, `FU_VALID`=0, `FU_OP`/`FU_A`/`FU_B`/`FU_TAG`=0, `DISP_ERR`=0, `rr`=0. Reset mid-operation discards all in-flight state immediately.
- `BUSY` is driven from registers. It rises the cycle after the dispatch edge and falls the cycle after the grant edge. A granted entry can be re-dispatched in the cycle after `BUSY` falls.
- Latency, dispatch with both operands ready at edge N:
  - task in output stage at edge N+1;
  - `FU_VALID` high from cycle N+1 until the handshake.
- Latency, last missing operand arrives on CDB at edge M: `FU_VALID` is high from cycle M+1 if the output stage was open at edge M+1.
- Back-to-back throughput: one task per cycle while `FU_READY` is held high and entries are READY.
- Full bank: all `BUSY` bits high, so the dispatcher must stall. A dispatch arriving anyway triggers the `DISP_ERR` path above.

## Test plan
- Reset then idle:
  - drive `RST_N`=0 mid-cycle → all outputs 0 asynchronously;
  - release, then 5 idle cycles → `BUSY`=2'b00, `FU_VALID`=0.
- Ready dispatch:
  - stimulus: entry 0, QJ=QK=0, VJ=32'h5, VK=32'h7, DEST=4'h3, op=7'h33, `FU_READY`=1;
  - response: `BUSY[0]`=1 for one cycle, then `FU_VALID`=1 with `FU_A`=5, `FU_B`=7, `FU_TAG`=3, then `BUSY[0]`=0.
- CDB wakeup:
  - stimulus: dispatch with QJ=4'h9 and QK=0 (VK=1), hold 3 cycles, then `CDB_VALID`=1, `CDB_TAG`=9, `CDB_DATA`=32'hAB;
  - response: `FU_VALID` rises the next cycle with `FU_A`=32'hAB, `FU_B`=1.
- Same-cycle bypass: dispatch QK=4'h2 while `CDB_TAG`=2 and `CDB_DATA`=32'h10 → entry is READY immediately and `FU_B`=32'h10.
- Backpressure and round-robin:
  - stimulus: both entries READY, `FU_READY`=0 for 4 cycles, then 1;
  - response: output is held stable; entry 0 issues first, then entry 1; `rr` wraps to 0.
- Errors and flush:
  - dispatch to a busy entry → `DISP_ERR`=1 and the entry is unchanged;
  - `FLUSH` together with a dispatch → `BUSY`=0, `FU_VALID`=0, and `DISP_ERR` stays 1.
